// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width and ALU operation codes.
package cpu_defs;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;

endpackage

// File: rtl/ALU.sv
// Single-cycle CPU ALU: result plus an unsigned compare flag per op code.
module ALU
    import cpu_defs::*;
(
    input  logic [DATA_W-1:0] Src1,
    input  logic [DATA_W-1:0] Src2,
    input  logic [3:0]        ALUOP,
    output logic [DATA_W-1:0] Result,
    output logic              Branch
);

    // Pure combinational op decode; undefined op codes yield zero.
    always_comb begin
        Result = '0;
        Branch = 1'b0;
        case (ALUOP)
            ALU_ADD: begin Result = Src1 + Src2;         Branch = (Src1 == Src2); end
            ALU_SUB: begin Result = Src1 - Src2;         Branch = (Src1 >= Src2); end
            ALU_AND: begin Result = Src1 & Src2;         Branch = (Src1 >  Src2); end
            ALU_OR:  begin Result = Src1 | Src2;         Branch = (Src1 <= Src2); end
            ALU_XOR: begin Result = Src1 ^ Src2;         Branch = (Src1 <  Src2); end
            ALU_LUI: begin Result = {Src2[15:0], 16'h0}; Branch = (Src1 != Src2); end
            default: begin Result = '0;                  Branch = 1'b0;           end
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names who wins a tie.
module rr_arb2 #(
    parameter int PRIO_INIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] elig_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // One-hot grant: a lone requester wins outright, a tie goes to the pointer.
    always_comb begin
        gnt_o = elig_i;
        if (elig_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After any grant, priority passes to the requester that lost.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Priority pointer register, restored to the configured owner on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'(PRIO_INIT);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters with registered, backpressurable responses.
module alu_share_arbiter
    import cpu_defs::*;
#(
    parameter int PRIO_INIT = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_src1_0,
    input  logic [DATA_W-1:0] req_src1_1,
    input  logic [DATA_W-1:0] req_src2_0,
    input  logic [DATA_W-1:0] req_src2_1,
    input  logic [3:0]        req_op_0,
    input  logic [3:0]        req_op_1,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DATA_W-1:0] resp_result_0,
    output logic [DATA_W-1:0] resp_result_1,
    output logic              resp_branch_0,
    output logic              resp_branch_1,
    output logic [CNT_W-1:0]  gnt_cnt_0,
    output logic [CNT_W-1:0]  gnt_cnt_1
);

    logic [1:0]              elig;
    logic [1:0]              gnt;
    logic [DATA_W-1:0]       alu_src1;
    logic [DATA_W-1:0]       alu_src2;
    logic [3:0]              alu_op;
    logic [DATA_W-1:0]       alu_result;
    logic                    alu_branch;

    logic [1:0]              valid_q;
    logic [1:0][DATA_W-1:0]  result_q;
    logic [1:0]              branch_q;
    logic [1:0][CNT_W-1:0]   cnt_q;
    logic [1:0][CNT_W-1:0]   cnt_d;

    // A requester may issue only if its response slot is empty or draining now.
    assign elig = req_valid & (~valid_q | resp_ready);

    rr_arb2 #(
        .PRIO_INIT (PRIO_INIT)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .elig_i (elig),
        .gnt_o  (gnt)
    );

    assign req_ready = gnt;

    // Steer the granted requester's operands onto the shared ALU.
    always_comb begin
        alu_src1 = req_src1_0;
        alu_src2 = req_src2_0;
        alu_op   = req_op_0;
        if (gnt[1]) begin
            alu_src1 = req_src1_1;
            alu_src2 = req_src2_1;
            alu_op   = req_op_1;
        end
    end

    ALU u_alu (
        .Src1   (alu_src1),
        .Src2   (alu_src2),
        .ALUOP  (alu_op),
        .Result (alu_result),
        .Branch (alu_branch)
    );

    // One-entry response buffers: a grant loads, a consume empties, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            result_q <= '0;
            branch_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    valid_q[i]  <= 1'b1;
                    result_q[i] <= alu_result;
                    branch_q[i] <= alu_branch;
                end else if (resp_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Grant counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign resp_valid    = valid_q;
    assign resp_result_0 = result_q[0];
    assign resp_result_1 = result_q[1];
    assign resp_branch_0 = branch_q[0];
    assign resp_branch_1 = branch_q[1];
    assign gnt_cnt_0     = cnt_q[0];
    assign gnt_cnt_1     = cnt_q[1];

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the CPU's single-cycle 32-bit ALU between two requesters, for example the EX-stage operate path and a branch/compare helper, using valid/ready handshakes.
- Arbitration is round-robin.
- The ALU result and branch flag are registered into a per-requester one-entry response buffer, so each requester sees a 1-cycle-latency response it can backpressure.
- The block keeps saturating per-requester grant counters for performance bring-up.

Parameters:
- PRIO_INIT, default 0: requester holding priority after reset (0 or 1).
- CNT_W, default 16: width of each grant counter.

Ports:
- clk, input, 1: rising-edge clock, the only clock.
- reset, input, 1: asynchronous, active-low. reset=0 clears state immediately, independent of clk.
- req_valid, input, 2: bit i means requester i presents an operation.
- req_ready, output, 2: bit i means requester i's operation is accepted this cycle (the grant).
- req_src1_0 / req_src1_1, input, 32 each: operand 1 per requester.
- req_src2_0 / req_src2_1, input, 32 each: operand 2 per requester.
- req_op_0 / req_op_1, input, 4 each: ALU op code per requester.
- resp_valid, output, 2: bit i means requester i's response buffer is full.
- resp_ready, input, 2: bit i means requester i consumes its response this cycle.
- resp_result_0 / resp_result_1, output, 32 each: registered ALU result.
- resp_branch_0 / resp_branch_1, output, 1 each: registered compare flag.
- gnt_cnt_0 / gnt_cnt_1, output, CNT_W each: saturating accepted-op counts.

Behaviour:
- Reset (reset=0, asynchronous):
  - resp_valid=0; all resp_result and resp_branch = 0; gnt_cnt = 0.
  - Priority pointer = PRIO_INIT.
  - An operation in flight is discarded. No response is produced after reset releases.
- Op encoding, compares unsigned 32-bit:
  - 0: result src1+src2 (mod 2^32); branch = src1==src2.
  - 1: result src1-src2; branch = src1>=src2.
  - 2: result AND; branch = src1>src2.
  - 3: result OR; branch = src1<=src2.
  - 4: result XOR; branch = src1<src2.
  - 5: result src2<<16 (low 16 bits zero); branch = src1!=src2.
  - 6..15: result 0, branch 0. The op is still accepted and still responded to.
- Eligibility: requester i is eligible when req_valid[i] && (!resp_valid[i] || resp_ready[i]).
- Grant, combinational in the same cycle, at most one per cycle:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester named by the priority pointer.
  - Neither eligible: no grant; pointer unchanged.
- req_ready = one-hot grant vector, or 0. A requester must not make req_valid depend on req_ready. Operands must stay stable while valid and not ready.
- Pointer update on each grant: pointer = the other requester. With both requesters holding valid and draining responses, grants alternate 0,1,0,1,...
- Latency: the operation granted in cycle N is computed combinationally by the ALU on the muxed operands. It is registered at the edge ending cycle N. resp_valid[i]=1 with its data in cycle N+1.
- Response buffer i, per rising edge:
  - Grant to i: load result/branch, resp_valid[i]=1. This includes the same-cycle resp_ready[i] case, giving back-to-back throughput of 1 op/cycle.
  - Else if resp_ready[i]: resp_valid[i]=0. Data may hold its last value.
  - Else: hold result, branch and valid unchanged.
- resp_ready[i] while resp_valid[i]=0 is ignored.
- Full buffer: requester i stays ineligible while resp_valid[i]=1 and resp_ready[i]=0. The other requester may be granted that cycle.
- gnt_cnt_i increments on each grant to i and saturates at 2^CNT_W-1 (it does not wrap).
- Combined throughput is at most 1 op/cycle across both requesters.

Decomposition:
- Shared package (cpu_defs):
  - ALU op constants, 4-bit: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_LUI=5.
  - Data width constant 32.
- Datapath: instantiate the CPU's existing ALU module unchanged (Src1, Src2, ALUOP -> Result, Branch). Do not re-implement it.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with registered priority pointer.
- Response buffers and counters stay in the top module.

Test Plan:
- Reset: pulse reset low asynchronously between edges -> resp_valid=2'b00, results 0, gnt_cnt 0 immediately. After release with no requests, outputs stay 0.
- Single request: req0 op=0, src1=5, src2=7 -> req_ready=2'b01 in cycle N. Cycle N+1: resp_valid[0]=1, result_0=12, branch_0=0. With resp_ready[0]=1 in N+1, resp_valid[0]=0 in N+2.
- Round-robin, PRIO_INIT=0, both valid every cycle, resp_ready=2'b11 -> req_ready sequence 01,10,01,10. gnt_cnt_0=gnt_cnt_1=2 after 4 cycles.
- Backpressure: resp_valid[0]=1 held with resp_ready[0]=0 while both request -> req_ready[0]=0 every cycle, requester 1 granted every cycle. resp_result_0 stays constant until resp_ready[0]=1, then requester 0 is granted that same cycle.
- Arithmetic edges:
  - op=1, 3-5 -> 0xFFFFFFFE, branch 0.
  - op=0, 0xFFFFFFFF+1 -> 0, branch 0.
  - op=5, src1=0, src2=0x1234 -> 0x12340000, branch 1.
  - op=9 -> result 0, branch 0, still responded.
- Mid-flight reset and saturation:
  - Reset asserted the cycle after a grant -> no response after release; pointer back to PRIO_INIT.
  - With CNT_W=4, 20 grants to requester 1 -> gnt_cnt_1=15.
